// File: rtl/hcms_frame_sequencer_if.sv
// Byte stream handshake from the frame sequencer to the display serial shifter.
interface hcms_frame_sequencer_if;
    logic [7:0] byte_data;
    logic       byte_cmd;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data, byte_cmd, byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data, byte_cmd, byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/hcms_frame_sequencer.sv
// HCMS dot-matrix frame sequencer: reset hold, control word, 8-char column stream.
// Define HCMS_BRIGHTNESS_EN to add a brightness input that drives control word 0.
module hcms_frame_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_code,
    input  logic       refresh,
`ifdef HCMS_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    output logic       busy,
    output logic       done,
    output logic       disp_reset,
    hcms_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {RST_HOLD, CFG, IDLE, STREAM, FIN} state_t;

    state_t     state;
    logic [3:0] hold_cnt;
    logic [2:0] char_idx;
    logic [2:0] col_idx;
    logic [4:0] char_buf [8];

    logic [2:0] nxt_char;
    logic [2:0] nxt_col;
    logic [7:0] col_byte;
    logic [7:0] cw0;
    logic       xfer;
    logic       last_byte;
    logic       bright_chg;

    // Columns left to right, bit6 = top row; codes 18..31 fall to blank.
    function automatic logic [7:0] glyph_col(input logic [4:0] code,
                                             input logic [2:0] col);
        logic [39:0] g;
        case (code)
            5'd0:    g = 40'h3E_41_41_41_3E;
            5'd1:    g = 40'h00_21_7F_01_00;
            5'd2:    g = 40'h21_43_45_49_31;
            5'd3:    g = 40'h22_41_49_49_36;
            5'd4:    g = 40'h0C_14_24_7F_04;
            5'd5:    g = 40'h72_51_51_51_4E;
            5'd6:    g = 40'h1E_29_49_49_06;
            5'd7:    g = 40'h40_47_48_50_60;
            5'd8:    g = 40'h36_49_49_49_36;
            5'd9:    g = 40'h30_49_49_4A_3C;
            5'd10:   g = 40'h3F_48_48_48_3F;
            5'd11:   g = 40'h7F_49_49_49_36;
            5'd12:   g = 40'h3E_41_41_41_22;
            5'd13:   g = 40'h7F_41_41_22_1C;
            5'd14:   g = 40'h7F_49_49_49_41;
            5'd15:   g = 40'h7F_48_48_48_40;
            5'd17:   g = 40'h08_08_08_08_08;
            default: g = 40'h00_00_00_00_00;
        endcase
        g = g << {col, 3'b000};
        return g[39:32];
    endfunction

`ifdef HCMS_BRIGHTNESS_EN
    logic [3:0] bright_q;
    logic       cfg_entry;

    assign cw0        = {4'b0100, brightness};
    assign bright_chg = (brightness != bright_q);
    assign cfg_entry  = (state == RST_HOLD && hold_cnt == 4'd15) ||
                        (state == IDLE && bright_chg);

    always_ff @(posedge clk) begin
        if (reset)
            bright_q <= 4'h0;
        else if (cfg_entry)
            bright_q <= brightness;
    end
`else
    assign cw0        = 8'h4F;
    assign bright_chg = 1'b0;
`endif

    always_comb begin
        xfer      = bus.byte_valid && bus.byte_ready;
        last_byte = (char_idx == 3'd7) && (col_idx == 3'd4);
        nxt_char  = 3'd0;
        nxt_col   = 3'd0;
        if (state == STREAM) begin
            if (col_idx == 3'd4) begin
                nxt_char = char_idx + 3'd1;
            end else begin
                nxt_char = char_idx;
                nxt_col  = col_idx + 3'd1;
            end
        end
        col_byte = glyph_col(char_buf[nxt_char], nxt_col);
    end

    // Old code wins on a same-edge write because the read is taken pre-edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                char_buf[i] <= 5'd16;
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RST_HOLD;
            hold_cnt       <= 4'd0;
            char_idx       <= 3'd0;
            col_idx        <= 3'd0;
            bus.byte_valid <= 1'b0;
            bus.byte_data  <= 8'h00;
            bus.byte_cmd   <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            disp_reset     <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                RST_HOLD: begin
                    if (hold_cnt == 4'd15) begin
                        state          <= CFG;
                        disp_reset     <= 1'b0;
                        bus.byte_valid <= 1'b1;
                        bus.byte_data  <= cw0;
                        bus.byte_cmd   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                CFG: begin
                    if (xfer) begin
                        state          <= IDLE;
                        bus.byte_valid <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bright_chg) begin
                        state          <= CFG;
                        busy           <= 1'b1;
                        bus.byte_valid <= 1'b1;
                        bus.byte_data  <= cw0;
                        bus.byte_cmd   <= 1'b1;
                    end else if (refresh) begin
                        state          <= STREAM;
                        busy           <= 1'b1;
                        char_idx       <= 3'd0;
                        col_idx        <= 3'd0;
                        bus.byte_valid <= 1'b1;
                        bus.byte_data  <= col_byte;
                        bus.byte_cmd   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_byte) begin
                            state          <= FIN;
                            bus.byte_valid <= 1'b0;
                            done           <= 1'b1;
                        end else begin
                            char_idx      <= nxt_char;
                            col_idx       <= nxt_col;
                            bus.byte_data <= col_byte;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_hcms_frame_sequencer.sv
// Directed/randomized bench for hcms_frame_sequencer against a frame-level model.
// Define HCMS_BRIGHTNESS_EN to also exercise the brightness control word path.
module tb_hcms_frame_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [4:0] wr_code = 5'd0;
    logic       refresh = 1'b0;
    logic       busy;
    logic       done;
    logic       disp_reset;
`ifdef HCMS_BRIGHTNESS_EN
    logic [3:0] brightness = 4'hF;
`endif

    hcms_frame_sequencer_if bus ();

    hcms_frame_sequencer u_dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_code    (wr_code),
        .refresh    (refresh),
`ifdef HCMS_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy       (busy),
        .done       (done),
        .disp_reset (disp_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    logic [4:0] mbuf [8];
    logic [8:0] got [$];
    logic [8:0] exp_q [$];
    bit         done_seen;
    int         done_gap;
    bit         ab;
    logic [7:0] cw_now;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Glyph columns, left to right, bit6 = top row.
    function automatic logic [7:0] font(input int code, input int col);
        logic [39:0] g;
        case (code)
            0:  g = 40'h3E_41_41_41_3E;
            1:  g = 40'h00_21_7F_01_00;
            2:  g = 40'h21_43_45_49_31;
            3:  g = 40'h22_41_49_49_36;
            4:  g = 40'h0C_14_24_7F_04;
            5:  g = 40'h72_51_51_51_4E;
            6:  g = 40'h1E_29_49_49_06;
            7:  g = 40'h40_47_48_50_60;
            8:  g = 40'h36_49_49_49_36;
            9:  g = 40'h30_49_49_4A_3C;
            10: g = 40'h3F_48_48_48_3F;
            11: g = 40'h7F_49_49_49_36;
            12: g = 40'h3E_41_41_41_22;
            13: g = 40'h7F_41_41_22_1C;
            14: g = 40'h7F_49_49_49_41;
            15: g = 40'h7F_48_48_48_40;
            17: g = 40'h08_08_08_08_08;
            default: g = 40'h0;
        endcase
        return g[8*(4-col) +: 8];
    endfunction

    function automatic void build_exp();
        exp_q.delete();
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 5; k++)
                exp_q.push_back({1'b0, font(int'(mbuf[c]), k)});
    endfunction

    task automatic wr(input logic [2:0] a, input logic [4:0] c);
        wr_en = 1'b1;
        wr_addr = a;
        wr_code = c;
        tick();
        wr_en = 1'b0;
        mbuf[a] = c;
    endtask

    task automatic kick();
        bus.byte_ready = 1'b0;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        chk("kick_busy", 32'(busy), 32'd1);
        chk("kick_valid", 32'(bus.byte_valid), 32'd1);
    endtask

    task automatic startup(input logic [7:0] cw);
        int n = 0;
        chk("rst_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_disp", 32'(disp_reset), 32'd1);
        chk("rst_data", 32'(bus.byte_data), 32'd0);
        chk("rst_cmd", 32'(bus.byte_cmd), 32'd0);
        bus.byte_ready = 1'b0;
        reset = 1'b0;
        while (disp_reset === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("hold_len", 32'(n), 32'd16);
        chk("cfg_byte", 32'({bus.byte_valid, bus.byte_cmd, bus.byte_data}),
            32'({2'b11, cw}));
        repeat (3) tick();
        chk("cfg_stall", 32'({bus.byte_valid, bus.byte_cmd, bus.byte_data}),
            32'({2'b11, cw}));
        chk("cfg_busy", 32'(busy), 32'd1);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        chk("cfg_after_valid", 32'(bus.byte_valid), 32'd0);
        chk("cfg_after_busy", 32'(busy), 32'd0);
    endtask

    task automatic stream_run(input bit stall, input bit mid,
                              input int abort_at, output bit aborted);
        int         cyc = 0;
        int         last = 0;
        bit         held_v = 1'b0;
        logic [8:0] held = '0;
        got.delete();
        done_seen = 1'b0;
        done_gap = -1;
        aborted = 1'b0;
        while (cyc < 600) begin
            wr_en = 1'b0;
            refresh = 1'b0;
            if (held_v)
                chk("stall_hold",
                    32'({bus.byte_valid, bus.byte_cmd, bus.byte_data}),
                    32'({1'b1, held}));
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_gap = cyc - last;
                break;
            end
            bus.byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.byte_valid === 1'b1 && bus.byte_ready) begin
                got.push_back({bus.byte_cmd, bus.byte_data});
                last = cyc;
                if (mid && got.size() == 10) begin
                    wr_en = 1'b1;
                    wr_addr = 3'd7;
                    wr_code = 5'd17;
                    refresh = 1'b1;
                    mbuf[7] = 5'd17;
                end
                if (abort_at != 0 && got.size() == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
            end
            held_v = (bus.byte_valid === 1'b1) && !bus.byte_ready;
            held = {bus.byte_cmd, bus.byte_data};
            tick();
            cyc++;
        end
    endtask

    task automatic check_frame();
        int lim;
        build_exp();
        chk("n_xfer", 32'(got.size()), 32'd40);
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("done_gap", 32'(done_gap), 32'd1);
        lim = (got.size() < 40) ? got.size() : 40;
        for (int i = 0; i < lim; i++)
            chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
        wr_en = 1'b0;
        refresh = 1'b0;
        bus.byte_ready = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 8; i++) mbuf[i] = 5'd16;
        repeat (2) tick();
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_code = 5'd5;
        tick();
        wr_en = 1'b0;
        startup(8'h4F);

        wr(3'd0, 5'd1);
        kick();
        stream_run(1'b0, 1'b0, 0, ab);
        check_frame();

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++)
                wr(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            wr(3'($urandom_range(0, 7)), 5'd17);
            kick();
            stream_run(1'b1, 1'b0, 0, ab);
            check_frame();
        end

        wr(3'd7, 5'd3);
        kick();
        stream_run(1'b0, 1'b1, 0, ab);
        check_frame();
        repeat (3) tick();
        chk("no_requeue_busy", 32'(busy), 32'd0);
        chk("no_requeue_valid", 32'(bus.byte_valid), 32'd0);

        cw_now = 8'h4F;
`ifdef HCMS_BRIGHTNESS_EN
        brightness = 4'h3;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        chk("bri_byte", 32'({busy, bus.byte_valid, bus.byte_cmd, bus.byte_data}),
            32'({3'b111, 8'h43}));
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        chk("bri_after_valid", 32'(bus.byte_valid), 32'd0);
        repeat (2) tick();
        chk("bri_refresh_dropped", 32'({busy, bus.byte_valid}), 32'd0);
        cw_now = 8'h43;
`endif

        kick();
        stream_run(1'b0, 1'b0, 20, ab);
        chk("abort_reached", 32'(ab), 32'd1);
        tick();
        reset = 1'b1;
        wr_en = 1'b1;
        wr_addr = 3'd3;
        wr_code = 5'd8;
        tick();
        wr_en = 1'b0;
        bus.byte_ready = 1'b0;
        chk("abort_valid", 32'(bus.byte_valid), 32'd0);
        chk("abort_disp", 32'(disp_reset), 32'd1);
        for (int i = 0; i < 8; i++) mbuf[i] = 5'd16;
        tick();
        startup(cw_now);
        kick();
        stream_run(1'b1, 1'b0, 0, ab);
        check_frame();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
